// File: rtl/div3_pkg.sv
// Shared definitions for the serial divisible-by-three checker:
// the remainder state encoding and the default frame width.
package div3_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    R0 = 2'd0,
    R1 = 2'd1,
    R2 = 2'd2
  } rem_t;

endpackage

// File: rtl/div3_rem_step.sv
// One step of the mod-3 remainder machine: consuming bit b moves the
// remainder r to (2r + b) mod 3.
module div3_rem_step
  import div3_pkg::*;
(
  input  rem_t r,
  input  logic b,
  output rem_t r_next
);

  always_comb begin
    // NOTE: r_next gets a value on every path (default first), so no latch is inferred.
    r_next = R0;
    unique case (r)
      R0:      r_next = b ? R1 : R0;
      R1:      r_next = b ? R0 : R2;
      R2:      r_next = b ? R2 : R1;
      default: r_next = R0;
    endcase
  end

endmodule

// File: rtl/div3_stream.sv
// Serial MSB-first word assembler that reports the word's remainder mod 3,
// holding each result until the consumer takes it.
module div3_stream
  import div3_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_abort,
  output logic [WIDTH-1:0] out_number,
  output logic [1:0]       out_rem,
  output logic             out_is_div3,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  rem_t             rem_q, rem_d, rem_next;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] out_number_q, out_number_d;
  rem_t             out_rem_q, out_rem_d;
  logic             out_is_div3_q, out_is_div3_d;
  logic             out_valid_q, out_valid_d;
  logic             accept;

  div3_rem_step u_rem_step (
    .r      (rem_q),
    .b      (in_bit),
    .r_next (rem_next)
  );

  // Input stalls while a result is pending; out_valid is purely registered.
  assign in_ready = ~out_valid_q;
  assign accept   = in_valid & in_ready;

  always_comb begin
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    shift_d       = shift_q;
    out_number_d  = out_number_q;
    out_rem_d     = out_rem_q;
    out_is_div3_d = out_is_div3_q;
    out_valid_d   = out_valid_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Abort discards the partial frame (and any bit offered with it) but
    // never touches a pending result.
    if (in_abort) begin
      cnt_d   = '0;
      rem_d   = R0;
      shift_d = '0;
    end else if (accept) begin
      if (cnt_q == LAST_BIT) begin
        out_number_d  = {shift_q[WIDTH-2:0], in_bit};
        out_rem_d     = rem_next;
        out_is_div3_d = (rem_next == R0);
        out_valid_d   = 1'b1;
        cnt_d         = '0;
        rem_d         = R0;
        shift_d       = '0;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        rem_d   = rem_next;
        shift_d = {shift_q[WIDTH-2:0], in_bit};
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      rem_q         <= R0;
      shift_q       <= '0;
      out_number_q  <= '0;
      out_rem_q     <= R0;
      out_is_div3_q <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      shift_q       <= shift_d;
      out_number_q  <= out_number_d;
      out_rem_q     <= out_rem_d;
      out_is_div3_q <= out_is_div3_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign out_number  = out_number_q;
  assign out_rem     = out_rem_q;
  assign out_is_div3 = out_is_div3_q;
  assign out_valid   = out_valid_q;

endmodule
